vga_pixel_engine: RTL and testbench

VGA_PIXEL_ENGINE -- requirements
Module: vga_pixel_engine

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_delay_line.sv | 24 ++
 rtl/vga_pixel_engine.sv | 106 ++++++++++
 tb/tb_vga_pixel_engine.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: source-select modes, 640x480@60 default timing and width helpers shared by the VGA pixel engine
package vga_pkg;
  typedef enum logic [1:0] {MODE_EXT, MODE_BARS, MODE_GRID, MODE_BORDER} mode_e;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  function automatic int clog2w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int seg_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit wide, D-deep shift register; D=0 degenerates to a wire
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clock,
  input  logic         RSTN,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (D == 0) begin : g_wire
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [D];
    always_ff @(posedge clock or negedge RSTN)
      if (!RSTN) begin
        for (int i = 0; i < D; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[D-1];
  end
endmodule

// File: rtl/vga_pixel_engine.sv
// vga_pixel_engine: VGA timing generator that requests pixels from a fixed-latency source
// and overlays optional test patterns on the registered colour output
module vga_pixel_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CW       = 4,
  parameter int LAT      = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                          clock,
  input  logic                          RSTN,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic [3*CW-1:0]               pix_in,
  output logic                          req,
  output logic [clog2w(H_ACTIVE)-1:0]   x,
  output logic [clog2w(V_ACTIVE)-1:0]   y,
  output logic                          line_start,
  output logic                          frame_start,
  output logic [CW-1:0]                 R,
  output logic [CW-1:0]                 G,
  output logic [CW-1:0]                 B,
  output logic                          HS,
  output logic                          VS
);
  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = clog2w(H_TOTAL);
  localparam int VW = clog2w(V_TOTAL);
  localparam int XW = clog2w(H_ACTIVE);
  localparam int YW = clog2w(V_ACTIVE);
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int DW = XW + YW + 3;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  mode_e mode_q;
  logic run, h_act, v_act, hs_a, vs_a, h_last;
  logic [DW-1:0] d_in, d_out;
  logic d_hs, d_vs, d_act;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic [2:0] bar;
  logic grid, border;
  logic [3*CW-1:0] rgb_n;
  // Reset also gates the counter-stage outputs so pulses stay low while held in reset
  assign run = en & RSTN;
  assign h_act = int'(h) >= H_START && int'(h) < H_START + H_ACTIVE;
  assign v_act = int'(v) >= V_START && int'(v) < V_START + V_ACTIVE;
  assign h_last = int'(h) == H_TOTAL - 1;
  assign req = run && h_act && v_act;
  assign x = req ? XW'(int'(h) - H_START) : '0;
  assign y = req ? YW'(int'(v) - V_START) : '0;
  assign line_start = run && h == '0;
  assign frame_start = line_start && v == '0;
  assign hs_a = run && int'(h) < H_SYNC;
  assign vs_a = run && int'(v) < V_SYNC;
  assign d_in = {hs_a, vs_a, req, x, y};
  always_ff @(posedge clock or negedge RSTN)
    if (!RSTN) begin
      h <= '0;
      v <= '0;
      mode_q <= MODE_EXT;
    end else begin
      h <= !en || h_last ? '0 : h + HW'(1);
      v <= !en ? '0 : !h_last ? v : int'(v) == V_TOTAL - 1 ? '0 : v + VW'(1);
      mode_q <= frame_start ? mode_e'(mode) : mode_q;
    end
  vga_delay_line #(.W(DW), .D(LAT)) u_delay (
    .clock (clock),
    .RSTN  (RSTN),
    .d     (d_in),
    .q     (d_out)
  );
  assign {d_hs, d_vs, d_act, dx, dy} = d_out;
  // Bar index is found by comparing against constant boundaries instead of dividing x
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) bar = int'(dx) >= k * H_ACTIVE / 8 ? 3'(k) : bar;
    grid = (dx & XW'(15)) == '0 || (dy & YW'(15)) == '0;
    border = dx == '0 || int'(dx) == H_ACTIVE - 1 || dy == '0 || int'(dy) == V_ACTIVE - 1;
    rgb_n = !d_act ? '0
          : mode_q == MODE_BARS ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}}
          : mode_q == MODE_GRID ? {3*CW{grid}}
          : mode_q == MODE_BORDER && border ? {{CW{1'b1}}, {2*CW{1'b0}}}
          : pix_in;
  end
  always_ff @(posedge clock or negedge RSTN)
    if (!RSTN) begin
      {B, G, R} <= '0;
      HS <= ~SYNC_POL;
      VS <= ~SYNC_POL;
    end else begin
      {B, G, R} <= rgb_n;
      HS <= d_hs ? SYNC_POL : ~SYNC_POL;
      VS <= d_vs ? SYNC_POL : ~SYNC_POL;
    end
endmodule

// File: tb/tb_vga_pixel_engine.sv
// tb_vga_pixel_engine: scoreboard bench on a reduced timing with LAT=3 and a model pixel source
module tb_vga_pixel_engine;
  localparam int HA = 32, HFP = 4, HSY = 6, HBP = 5;
  localparam int VA = 16, VFP = 2, VSY = 2, VBP = 3;
  localparam int CW = 4, LAT = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int XW = $clog2(HA), YW = $clog2(VA);
  localparam int FRAME = HT * VT;
  localparam logic [13:0] BLANK = {12'h000, 2'b11};
  logic clock = 1'b0;
  logic RSTN = 1'b1;
  logic en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3*CW-1:0] pix_in = '0;
  logic req, line_start, frame_start, HS, VS;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] R, G, B;
  int checks = 0, passed = 0;
  int mh = 0, mv = 0;
  logic [1:0] mmode = 2'b00;
  logic [13:0] outq[$];
  logic [11:0] pipe[LAT];
  always #5 clock = ~clock;
  vga_pixel_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CW(CW), .LAT(LAT), .SYNC_POL(1'b0)
  ) dut (
    .clock(clock), .RSTN(RSTN), .en(en), .mode(mode), .pix_in(pix_in),
    .req(req), .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .R(R), .G(G), .B(B), .HS(HS), .VS(VS)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
  endtask
  task automatic prime_queue();
    outq.delete();
    repeat (LAT + 1) outq.push_back(BLANK);
  endtask
  // One pixel clock: compare at negedge, then advance the model just after the posedge
  task automatic cycle();
    bit run, act, hsa, vsa, fs;
    int mx, my;
    logic [2:0] bk;
    logic [11:0] pv, bgr;
    @(negedge clock);
    run = en && RSTN;
    act = run && mh >= HSY + HBP && mh < HSY + HBP + HA && mv >= VSY + VBP && mv < VSY + VBP + VA;
    mx = act ? mh - (HSY + HBP) : 0;
    my = act ? mv - (VSY + VBP) : 0;
    hsa = run && mh < HSY;
    vsa = run && mv < VSY;
    fs = run && mh == 0 && mv == 0;
    check("comb", {req, x, y, line_start, frame_start}, {act, XW'(mx), YW'(my), run && mh == 0, fs});
    pv = {4'(my), 4'(mx + my), 4'(mx)};
    bk = 3'(mx * 8 / HA);
    if (!act) bgr = 12'h000;
    else if (mmode == 2'b01) bgr = {{4{bk[2]}}, {4{bk[1]}}, {4{bk[0]}}};
    else if (mmode == 2'b10) bgr = (mx % 16 == 0 || my % 16 == 0) ? 12'hFFF : 12'h000;
    else if (mmode == 2'b11 && (mx == 0 || mx == HA - 1 || my == 0 || my == VA - 1)) bgr = 12'hF00;
    else bgr = pv;
    check("out", {R, G, B, HS, VS}, outq.pop_front());
    outq.push_back({bgr[3:0], bgr[7:4], bgr[11:8], !hsa, !vsa});
    @(posedge clock);
    #1;
    if (!RSTN) mmode = 2'b00;
    else if (fs) mmode = mode;
    if (!run) begin
      mh = 0;
      mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else mh++;
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = act ? pv : 12'h5A5;
    pix_in = pipe[LAT-1];
  endtask
  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask
  task automatic wait_until(input int th, input int tv);
    int n = 0;
    while (!(mh == th && mv == tv) && n < 3 * FRAME) begin
      cycle();
      n++;
    end
    if (n >= 3 * FRAME) check("wait_timeout", 0, 1);
  endtask
  initial begin
    for (int i = 0; i < LAT; i++) pipe[i] = 12'h000;
    prime_queue();
    en = 1'b1;
    #1 RSTN = 1'b0;
    #1;
    check("rst_out", {R, G, B, HS, VS}, BLANK);
    check("rst_comb", {req, x, y, line_start, frame_start}, 0);
    run_n(4);
    RSTN = 1'b1;
    #1;
    check("fs_release", {frame_start, line_start, req}, 3'b110);
    run_n(FRAME + 5);
    wait_until(20, 10);
    mode = 2'b01;
    run_n(2 * FRAME);
    wait_until(20, 12);
    mode = 2'b10;
    run_n(2 * FRAME);
    wait_until(10, 8);
    mode = 2'b11;
    run_n(2 * FRAME);
    mode = 2'b00;
    run_n(FRAME);
    wait_until(HSY + HBP + 10, VSY + VBP + 5);
    en = 1'b0;
    cycle();
    check("req_en_low", req, 0);
    run_n(LAT + 4);
    check("blank_en_low", {R, G, B, HS, VS}, BLANK);
    en = 1'b1;
    #1;
    check("fs_en_rise", frame_start, 1);
    mode = 2'b01;
    run_n(FRAME + 10);
    wait_until(HSY + HBP + 14, VSY + VBP + 7);
    RSTN = 1'b0;
    #1;
    check("rst_mid_out", {R, G, B, HS, VS}, BLANK);
    check("rst_mid_comb", {req, x, y, line_start, frame_start}, 0);
    prime_queue();
    mh = 0;
    mv = 0;
    mmode = 2'b00;
    run_n(3);
    RSTN = 1'b1;
    #1;
    check("fs_release2", frame_start, 1);
    run_n(FRAME + LAT + 2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
